// File: rtl/ipsxe_floating_point_adder_pipe_v2_0_pkg.sv
// ipsxe_floating_point_adder_pipe_v2_0_pkg: shared floating-point widths and pipeline stage indices
package ipsxe_floating_point_adder_pipe_v2_0_pkg;
    localparam int S1 = 0, S2 = 1, S3 = 2, S4 = 3;
    function automatic int prod_w(input int man_w);
        return 2 * (man_w + 1);
    endfunction
    function automatic int sum_w(input int man_w);
        return prod_w(man_w) + 2;
    endfunction
    function automatic int in_w(input int exp_w, input int man_w);
        return prod_w(man_w) + exp_w + 2;
    endfunction
    // sign + (exp_w+1)-bit exponent + (P+1)-bit magnitude
    function automatic int out_w(input int exp_w, input int man_w);
        return prod_w(man_w) + exp_w + 3;
    endfunction
endpackage

// File: rtl/ipsxe_floating_point_adder_pipe_v2_0_align_shift.sv
// ipsxe_floating_point_align_shift_v1_0: alignment right shift with sticky OR of discarded bits
module ipsxe_floating_point_align_shift_v1_0 #(
    parameter int WIDTH = 48,
    parameter int SHIFT_WIDTH = 9
) (
    input  logic [WIDTH-1:0]       din,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [WIDTH-1:0]       dout,
    output logic                   sticky
);
    // shifts of WIDTH or more give zero data and an all-ones discard mask
    assign dout = din >> shift;
    assign sticky = |(din & ~({WIDTH{1'b1}} << shift));
endmodule

// File: rtl/ipsxe_floating_point_adder_pipe_v2_0.sv
// ipsxe_floating_point_adder_pipe_v2_0: four-stage product-plus-addend aligner/adder, unnormalised output
module ipsxe_floating_point_adder_pipe_v2_0
    import ipsxe_floating_point_adder_pipe_v2_0_pkg::*;
#(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter logic [3:0] PIPE_EN = 4'b1111,
    parameter int W_USER = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_aclken,
    input  logic                                   i_valid,
    input  logic [in_w(EXP_WIDTH, MAN_WIDTH)-1:0]  i_a_mul_b,
    input  logic                                   i_sign_c,
    input  logic [EXP_WIDTH:0]                     i_exp_c,
    input  logic [MAN_WIDTH-1:0]                   i_man_c,
    input  logic                                   i_c_is_0,
    input  logic                                   i_sub,
    input  logic [W_USER-1:0]                      i_user,
    output logic                                   o_valid,
    output logic [out_w(EXP_WIDTH, MAN_WIDTH)-1:0] o_add_out,
    output logic                                   o_sticky,
    output logic [W_USER-1:0]                      o_user
);
    localparam int P = prod_w(MAN_WIDTH);
    localparam int SW = sum_w(MAN_WIDTH);
    localparam int EW = EXP_WIDTH + 1;
    localparam int W1 = 1 + W_USER + 2 * (1 + P) + 2 * EW;
    localparam int W2 = 1 + W_USER + 2 * (1 + P) + EW + 1;
    localparam int W3 = 1 + W_USER + SW + EW + 1;
    localparam int W4 = 1 + W_USER + out_w(EXP_WIDTH, MAN_WIDTH) + 1;

    logic [W1-1:0] s1_d, s1_q;
    logic [W2-1:0] s2_d, s2_q;
    logic [W3-1:0] s3_d, s3_q;
    logic [W4-1:0] s4_d, s4_q;

    logic sp, sc, p_big;
    logic [EW-1:0] ep;
    logic [P-1:0] mp, mc;
    assign {sp, ep, mp} = i_a_mul_b;
    assign mc = {1'b0, ~i_c_is_0, i_man_c, {MAN_WIDTH{1'b0}}};
    assign sc = i_sign_c ^ i_sub;
    assign p_big = ep >= i_exp_c;
    assign s1_d = p_big ? {i_valid, i_user, sp, ep, mp, sc, mc, ep - i_exp_c}
                        : {i_valid, i_user, sc, i_exp_c, mc, sp, mp, i_exp_c - ep};

    logic v1, bs1, ss1, st1;
    logic [W_USER-1:0] u1;
    logic [EW-1:0] be1, df1;
    logic [P-1:0] bm1, sm1, sh1;
    assign {v1, u1, bs1, be1, bm1, ss1, sm1, df1} = s1_q;
    ipsxe_floating_point_align_shift_v1_0 #(.WIDTH(P), .SHIFT_WIDTH(EW)) u_align (
        .din(sm1), .shift(df1), .dout(sh1), .sticky(st1)
    );
    assign s2_d = {v1, u1, bs1, be1, bm1, ss1, sh1, st1};

    logic v2, bs2, ss2, st2;
    logic [W_USER-1:0] u2;
    logic [EW-1:0] be2;
    logic [P-1:0] bm2, sh2;
    logic [SW-1:0] bx, sx, sum;
    assign {v2, u2, bs2, be2, bm2, ss2, sh2, st2} = s2_q;
    assign bx = {2'b00, bm2};
    assign sx = {2'b00, sh2};
    assign sum = (bs2 ? -bx : bx) + (ss2 ? -sx : sx);
    assign s3_d = {v2, u2, sum, be2, st2};

    // |sum| < 2^(P+1), so the low P+1 bits of the negation are the full magnitude
    logic v3, st3;
    logic [W_USER-1:0] u3;
    logic [SW-1:0] sm3;
    logic [EW-1:0] be3;
    logic [P:0] mag;
    assign {v3, u3, sm3, be3, st3} = s3_q;
    assign mag = sm3[SW-1] ? (~sm3[P:0]) + (P+1)'(1) : sm3[P:0];
    assign s4_d = {v3, u3, sm3[SW-1], be3, mag, st3};
    assign {o_valid, o_user, o_add_out, o_sticky} = s4_q;

    if (PIPE_EN[S1]) begin : g_s1
        always_ff @(posedge i_clk or posedge i_rst)
            if (i_rst) s1_q <= '0;
            else if (i_aclken) s1_q <= s1_d;
    end else begin : g_s1_comb
        assign s1_q = s1_d;
    end
    if (PIPE_EN[S2]) begin : g_s2
        always_ff @(posedge i_clk or posedge i_rst)
            if (i_rst) s2_q <= '0;
            else if (i_aclken) s2_q <= s2_d;
    end else begin : g_s2_comb
        assign s2_q = s2_d;
    end
    if (PIPE_EN[S3]) begin : g_s3
        always_ff @(posedge i_clk or posedge i_rst)
            if (i_rst) s3_q <= '0;
            else if (i_aclken) s3_q <= s3_d;
    end else begin : g_s3_comb
        assign s3_q = s3_d;
    end
    if (PIPE_EN[S4]) begin : g_s4
        always_ff @(posedge i_clk or posedge i_rst)
            if (i_rst) s4_q <= '0;
            else if (i_aclken) s4_q <= s4_d;
    end else begin : g_s4_comb
        assign s4_q = s4_d;
    end
endmodule

// File: tb/tb_ipsxe_floating_point_adder_pipe_v2_0.sv
// tb_ipsxe_floating_point_adder_pipe_v2_0: scoreboard bench with directed vectors for the adder pipe
module tb_ipsxe_floating_point_adder_pipe_v2_0;
    localparam int EW = 8, MW = 23, P = 48, UW = 4, OW = P + EW + 3;
    localparam logic [P-1:0] ONE = 48'h4000_0000_0000;

    logic i_clk = 0, i_rst = 0, i_aclken = 0, i_valid = 0;
    logic i_sign_c = 0, i_c_is_0 = 0, i_sub = 0;
    logic [P+EW+1:0] i_a_mul_b = '0;
    logic [EW:0] i_exp_c = '0;
    logic [MW-1:0] i_man_c = '0;
    logic [UW-1:0] i_user = '0, o_user;
    logic o_valid, o_sticky;
    logic [OW-1:0] o_add_out, prev_out;

    typedef struct packed {
        logic [UW-1:0] user;
        logic [OW-1:0] out;
        logic sticky;
        int unsigned en;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int errors = 0, checks = 0;
    int unsigned en_cnt = 0, cyc = 0, last_pop = 0, pulses = 0, t0 = 0;
    logic last_en = 0;

    ipsxe_floating_point_adder_pipe_v2_0 #(
        .EXP_WIDTH(EW), .MAN_WIDTH(MW), .PIPE_EN(4'b1111), .W_USER(UW)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_aclken(i_aclken), .i_valid(i_valid),
        .i_a_mul_b(i_a_mul_b), .i_sign_c(i_sign_c), .i_exp_c(i_exp_c), .i_man_c(i_man_c),
        .i_c_is_0(i_c_is_0), .i_sub(i_sub), .i_user(i_user),
        .o_valid(o_valid), .o_add_out(o_add_out), .o_sticky(o_sticky), .o_user(o_user)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        last_en <= i_aclken && !i_rst;
        if (i_aclken && !i_rst) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor: a new output is one presented after an enabled edge; disabled edges must hold it
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && last_en) begin
            pulses++;
            last_pop = cyc;
            if (q.size() == 0) check("unexpected_valid", o_valid, 1'b0);
            else begin
                e = q.pop_front();
                check("result", {o_user, o_add_out, o_sticky}, {e.user, e.out, e.sticky});
                check("latency", en_cnt, e.en);
            end
        end else if (!i_rst && o_valid && !last_en) check("hold", o_add_out, prev_out);
        prev_out = o_add_out;
    end

    task automatic send(input logic [UW-1:0] u, input logic sp, input logic [EW:0] ep, input logic [P-1:0] mp,
                        input logic sc, input logic [EW:0] ec, input logic [MW-1:0] mc, input logic cz,
                        input logic sub, input logic rs, input logic [EW:0] re, input logic [P:0] ra,
                        input logic rst_);
        @(negedge i_clk);
        i_aclken = 1; i_valid = 1; i_user = u;
        i_a_mul_b = {sp, ep, mp}; i_sign_c = sc; i_exp_c = ec; i_man_c = mc; i_c_is_0 = cz; i_sub = sub;
        q.push_back('{u, {rs, re, ra}, rst_, en_cnt + 4});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            i_aclken = 1; i_valid = 0;
        end
    endtask

    initial begin
        #1 i_rst = 1;
        #1;
        check("reset_valid", o_valid, 1'b0);
        check("reset_out", o_add_out, '0);
        repeat (2) @(negedge i_clk);
        i_rst = 0;
        idle(2);
        // directed vectors: u, sp, ep, mp, sc, ec, mc, cz, sub -> sign, exp, abs, sticky
        send(1, 0, 254, ONE, 0, 254, 0, 0, 0, 0, 254, 49'h0_8000_0000_0000, 0);
        send(2, 0, 254, ONE, 0, 254, 0, 0, 1, 0, 254, 49'h0, 0);
        send(3, 0, 254, ONE, 0, 194, 0, 0, 0, 0, 254, 49'h0_4000_0000_0000, 1);
        send(4, 0, 254, ONE, 1, 255, 0, 0, 0, 1, 255, 49'h0_2000_0000_0000, 0);
        send(5, 0, 254, ONE, 0, 254, 0, 1, 0, 0, 254, 49'h0_4000_0000_0000, 0);
        send(6, 0, 254, ONE, 0, 224, 1, 0, 0, 0, 254, 49'h0_4000_0001_0000, 1);
        send(7, 0, 254, ONE, 0, 208, 0, 0, 0, 0, 254, 49'h0_4000_0000_0001, 0);
        send(8, 0, 254, ONE, 0, 207, 0, 0, 0, 0, 254, 49'h0_4000_0000_0000, 1);
        send(9, 1, 254, ONE, 0, 253, 0, 0, 0, 1, 254, 49'h0_2000_0000_0000, 0);
        idle(6);
        // stream with a three-cycle clock-enable drop after the fourth sample
        send(8, 0, 254, ONE, 0, 254, 0, 0, 0, 0, 254, 49'h0_8000_0000_0000, 0);
        t0 = cyc;
        send(9, 0, 254, ONE, 0, 253, 0, 0, 0, 0, 254, 49'h0_6000_0000_0000, 0);
        send(10, 0, 254, ONE, 0, 252, 0, 0, 0, 0, 254, 49'h0_5000_0000_0000, 0);
        send(11, 0, 254, ONE, 0, 251, 0, 0, 0, 0, 254, 49'h0_4800_0000_0000, 0);
        repeat (3) @(negedge i_clk) i_aclken = 0;
        send(12, 0, 254, ONE, 0, 250, 0, 0, 1, 0, 254, 49'h0_3C00_0000_0000, 0);
        send(13, 0, 254, ONE, 0, 249, 0, 0, 1, 0, 254, 49'h0_3E00_0000_0000, 0);
        send(14, 0, 254, ONE, 0, 200, 0, 0, 0, 0, 254, 49'h0_4000_0000_0000, 1);
        send(15, 0, 254, ONE, 0, 255, 0, 0, 1, 1, 255, 49'h0_2000_0000_0000, 0);
        idle(1);
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        check("drain_empty", q.size(), 0);
        check("stall_last_cycle", last_pop - t0, 14);
        // reset with one sample at the output and three in flight
        send(1, 0, 254, ONE, 0, 254, 0, 0, 0, 0, 254, 49'h0_8000_0000_0000, 0);
        send(2, 0, 254, ONE, 0, 254, 0, 0, 1, 0, 254, 49'h0, 0);
        send(3, 0, 254, ONE, 0, 253, 0, 0, 0, 0, 254, 49'h0_6000_0000_0000, 0);
        send(4, 0, 254, ONE, 0, 252, 0, 0, 0, 0, 254, 49'h0_5000_0000_0000, 0);
        send(5, 0, 254, ONE, 0, 251, 0, 0, 0, 0, 254, 49'h0_4800_0000_0000, 0);
        @(negedge i_clk);
        i_valid = 0;
        #2 i_rst = 1;
        #1;
        check("rst_async_valid", o_valid, 1'b0);
        check("rst_async_out", o_add_out, '0);
        q.delete();
        pulses = 0;
        repeat (2) @(negedge i_clk);
        i_rst = 0;
        idle(10);
        check("no_pulse_after_reset", pulses, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
